usopenhpsdr1_framer: RTL and testbench

Upstream (card->PC) OpenHPSDR protocol-1 EP6 packet framer. It sits between the receiver IQ sample FIFO and the Ethernet UDP transmit path. It emits 1032-byte payloads (8-byte Metis header plus two 512-byte USB frames), carrying control/status bytes C0..C4 and interleaved multi-receiver IQ. It is the transmit-side counterpart of the downstream command/IQ unpacker.

---
 rtl/usopenhpsdr1_framer.sv | 332 +++++++++++++++++++++++++++++++++
 tb/tb_usopenhpsdr1_framer.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usopenhpsdr1_framer.sv
// usopenhpsdr1_framer
// Upstream OpenHPSDR protocol-1 EP6 packet framer. Builds 1032-byte payloads:
// an 8-byte Metis header followed by two 512-byte USB frames. Each frame holds
// sync (7F 7F 7F), control bytes C0..C4, interleaved IQ slots for 1..8
// receivers with a two-byte mic field per slot, and zero padding to 512 bytes.
//
// Ports
//   clk, rst                  clock and asynchronous active-high reset
//   run, nrx, pkt_ready       streaming enable, receivers-1, FIFO has a packet
//   iq_tdata/tvalid/tready    {I[23:0], Q[23:0]} per receiver; tready pulses on Q0
//   ptt_in                    reported in C0[0]
//   resp_valid/addr/data      command response, sent in the next control slot
//   status_sel, status_data   round-robin status word select and its value
//   us_tdata/tvalid/tready/tlast  byte stream to the UDP transmit path
//   seqno                     packet sequence number
module usopenhpsdr1_framer (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [2:0]  nrx,
  input  logic        pkt_ready,
  input  logic [47:0] iq_tdata,
  input  logic        iq_tvalid,
  output logic        iq_tready,
  input  logic        ptt_in,
  input  logic        resp_valid,
  input  logic [5:0]  resp_addr,
  input  logic [31:0] resp_data,
  output logic [1:0]  status_sel,
  input  logic [31:0] status_data,
  output logic [7:0]  us_tdata,
  output logic        us_tvalid,
  input  logic        us_tready,
  output logic        us_tlast,
  output logic [31:0] seqno
);

  typedef enum logic [2:0] {StIdle, StHdr, StSync, StCtrl, StIq, StMic, StPad} state_e;

  // Last slot index per frame for 1..8 receivers (slots = 504 / (6n + 2)).
  function automatic logic [5:0] slot_last_of(input logic [2:0] n);
    logic [5:0] r;
    unique case (n)
      3'd0:    r = 6'd62;
      3'd1:    r = 6'd35;
      3'd2:    r = 6'd24;
      3'd3:    r = 6'd18;
      3'd4:    r = 6'd14;
      3'd5:    r = 6'd12;
      3'd6:    r = 6'd10;
      default: r = 6'd9;
    endcase
    return r;
  endfunction

  // Zero bytes needed after the last slot to fill the frame to 512 bytes.
  function automatic logic [4:0] pad_len_of(input logic [2:0] n);
    logic [4:0] r;
    unique case (n)
      3'd0:    r = 5'd0;
      3'd1:    r = 5'd0;
      3'd2:    r = 5'd4;
      3'd3:    r = 5'd10;
      3'd4:    r = 5'd24;
      3'd5:    r = 5'd10;
      3'd6:    r = 5'd20;
      default: r = 5'd4;
    endcase
    return r;
  endfunction

  state_e      state_q, state_d;
  logic        frame_q, frame_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  rx_q, rx_d;
  logic [5:0]  slot_q, slot_d;
  logic [2:0]  nrx_q, nrx_d;
  logic [10:0] pos_q, pos_d;
  logic [31:0] seqno_q, seqno_d;
  logic        run_q;
  logic        pend_q, pend_d;
  logic [5:0]  pend_addr_q, pend_addr_d;
  logic [31:0] pend_data_q, pend_data_d;
  logic        ctrl_resp_q, ctrl_resp_d;
  logic [5:0]  ctrl_addr_q, ctrl_addr_d;
  logic [31:0] ctrl_word_q, ctrl_word_d;
  logic [39:0] iq_word_q, iq_word_d;
  logic [1:0]  status_sel_q, status_sel_d;

  logic        hs;
  logic        frame_done;
  logic [5:0]  slot_last;
  logic [4:0]  pad_n;

  assign slot_last  = slot_last_of(nrx_q);
  assign pad_n      = pad_len_of(nrx_q);
  assign hs         = us_tvalid & us_tready;
  assign status_sel = status_sel_q;
  assign seqno      = seqno_q;
  assign us_tlast   = (state_q != StIdle) && (pos_q == 11'd1031);
  assign iq_tready  = (state_q == StIq) && (cnt_q == 5'd5) && iq_tvalid && us_tready;

  // Byte presented for the current state/index; stable while the sink stalls.
  always_comb begin
    us_tvalid = 1'b0;
    us_tdata  = 8'h00;
    unique case (state_q)
      StIdle: begin
        us_tvalid = 1'b0;
      end
      StHdr: begin
        us_tvalid = 1'b1;
        unique case (cnt_q)
          5'd0:    us_tdata = 8'hEF;
          5'd1:    us_tdata = 8'hFE;
          5'd2:    us_tdata = 8'h01;
          5'd3:    us_tdata = 8'h06;
          5'd4:    us_tdata = seqno_q[31:24];
          5'd5:    us_tdata = seqno_q[23:16];
          5'd6:    us_tdata = seqno_q[15:8];
          default: us_tdata = seqno_q[7:0];
        endcase
      end
      StSync: begin
        us_tvalid = 1'b1;
        us_tdata  = 8'h7F;
      end
      StCtrl: begin
        us_tvalid = 1'b1;
        unique case (cnt_q)
          5'd0:    us_tdata = ctrl_resp_q ? {1'b1, ctrl_addr_q, ptt_in}
                                          : {3'b000, status_sel_q, 2'b00, ptt_in};
          5'd1:    us_tdata = ctrl_word_q[31:24];
          5'd2:    us_tdata = ctrl_word_q[23:16];
          5'd3:    us_tdata = ctrl_word_q[15:8];
          default: us_tdata = ctrl_word_q[7:0];
        endcase
      end
      StIq: begin
        us_tvalid = iq_tvalid;
        unique case (cnt_q)
          5'd0:    us_tdata = iq_tdata[47:40];
          5'd1:    us_tdata = iq_word_q[39:32];
          5'd2:    us_tdata = iq_word_q[31:24];
          5'd3:    us_tdata = iq_word_q[23:16];
          5'd4:    us_tdata = iq_word_q[15:8];
          default: us_tdata = iq_word_q[7:0];
        endcase
      end
      StMic, StPad: begin
        us_tvalid = 1'b1;
      end
      default: begin
        us_tvalid = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    frame_d      = frame_q;
    cnt_d        = cnt_q;
    rx_d         = rx_q;
    slot_d       = slot_q;
    nrx_d        = nrx_q;
    pos_d        = pos_q;
    seqno_d      = seqno_q;
    pend_d       = pend_q;
    pend_addr_d  = pend_addr_q;
    pend_data_d  = pend_data_q;
    ctrl_resp_d  = ctrl_resp_q;
    ctrl_addr_d  = ctrl_addr_q;
    ctrl_word_d  = ctrl_word_q;
    iq_word_d    = iq_word_q;
    status_sel_d = status_sel_q;
    frame_done   = 1'b0;

    if (hs) pos_d = pos_q + 11'd1;

    unique case (state_q)
      StIdle: begin
        if (run && !run_q) seqno_d = '0;
        if (run && pkt_ready) begin
          state_d = StHdr;
          cnt_d   = '0;
          frame_d = 1'b0;
          nrx_d   = nrx;
          pos_d   = '0;
        end
      end
      StHdr: begin
        if (hs) begin
          if (cnt_q == 5'd7) begin
            state_d = StSync;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      StSync: begin
        if (hs) begin
          if (cnt_q == 5'd2) begin
            state_d = StCtrl;
            cnt_d   = '0;
            // Snapshot the response (with same-cycle bypass) so C0..C4 stay coherent.
            ctrl_resp_d = pend_q | resp_valid;
            ctrl_addr_d = resp_valid ? resp_addr : pend_addr_q;
            ctrl_word_d = resp_valid ? resp_data : pend_data_q;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      StCtrl: begin
        if (hs) begin
          if (cnt_q == 5'd0 && !ctrl_resp_q) ctrl_word_d = status_data;
          if (cnt_q == 5'd4) begin
            if (!ctrl_resp_q) status_sel_d = status_sel_q + 2'd1;
            state_d = StIq;
            cnt_d   = '0;
            rx_d    = '0;
            slot_d  = '0;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      StIq: begin
        if (hs) begin
          if (cnt_q == 5'd0) iq_word_d = iq_tdata[39:0];
          if (cnt_q == 5'd5) begin
            cnt_d = '0;
            if (rx_q == nrx_q) begin
              state_d = StMic;
            end else begin
              rx_d = rx_q + 3'd1;
            end
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      StMic: begin
        if (hs) begin
          if (cnt_q == 5'd1) begin
            cnt_d = '0;
            if (slot_q == slot_last) begin
              if (pad_n == 5'd0) frame_done = 1'b1;
              else state_d = StPad;
            end else begin
              slot_d  = slot_q + 6'd1;
              rx_d    = '0;
              state_d = StIq;
            end
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      StPad: begin
        if (hs) begin
          if (cnt_q == pad_n - 5'd1) frame_done = 1'b1;
          else cnt_d = cnt_q + 5'd1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (frame_done) begin
      cnt_d = '0;
      if (!frame_q) begin
        frame_d = 1'b1;
        state_d = StSync;
      end else begin
        state_d = StIdle;
        seqno_d = seqno_q + 32'd1;
      end
    end

    // Clear first, then reload: a response arriving with the C4 handshake survives.
    if (state_q == StCtrl && hs && cnt_q == 5'd4 && ctrl_resp_q) pend_d = 1'b0;
    if (resp_valid) begin
      pend_d      = 1'b1;
      pend_addr_d = resp_addr;
      pend_data_d = resp_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      frame_q      <= 1'b0;
      cnt_q        <= '0;
      rx_q         <= '0;
      slot_q       <= '0;
      nrx_q        <= '0;
      pos_q        <= '0;
      seqno_q      <= '0;
      run_q        <= 1'b0;
      pend_q       <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
      ctrl_resp_q  <= 1'b0;
      ctrl_addr_q  <= '0;
      ctrl_word_q  <= '0;
      iq_word_q    <= '0;
      status_sel_q <= '0;
    end else begin
      state_q      <= state_d;
      frame_q      <= frame_d;
      cnt_q        <= cnt_d;
      rx_q         <= rx_d;
      slot_q       <= slot_d;
      nrx_q        <= nrx_d;
      pos_q        <= pos_d;
      seqno_q      <= seqno_d;
      run_q        <= run;
      pend_q       <= pend_d;
      pend_addr_q  <= pend_addr_d;
      pend_data_q  <= pend_data_d;
      ctrl_resp_q  <= ctrl_resp_d;
      ctrl_addr_q  <= ctrl_addr_d;
      ctrl_word_q  <= ctrl_word_d;
      iq_word_q    <= iq_word_d;
      status_sel_q <= status_sel_d;
    end
  end

endmodule

// File: tb/tb_usopenhpsdr1_framer.sv
// Testbench for usopenhpsdr1_framer: drives random IQ samples and sink stalls,
// collects the byte stream and compares it with packets built from the framing
// rules (header, sync, control, slots of 6n+2 bytes, zero fill to 512).
`timescale 1ns/1ps
module tb_usopenhpsdr1_framer;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [2:0]  nrx;
  logic        pkt_ready;
  logic [47:0] iq_tdata;
  logic        iq_tvalid;
  logic        iq_tready;
  logic        ptt_in;
  logic        resp_valid;
  logic [5:0]  resp_addr;
  logic [31:0] resp_data;
  logic [1:0]  status_sel;
  logic [31:0] status_data;
  logic [7:0]  us_tdata;
  logic        us_tvalid;
  logic        us_tready;
  logic        us_tlast;
  logic [31:0] seqno;

  always #5 clk = ~clk;

  usopenhpsdr1_framer dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .nrx         (nrx),
    .pkt_ready   (pkt_ready),
    .iq_tdata    (iq_tdata),
    .iq_tvalid   (iq_tvalid),
    .iq_tready   (iq_tready),
    .ptt_in      (ptt_in),
    .resp_valid  (resp_valid),
    .resp_addr   (resp_addr),
    .resp_data   (resp_data),
    .status_sel  (status_sel),
    .status_data (status_data),
    .us_tdata    (us_tdata),
    .us_tvalid   (us_tvalid),
    .us_tready   (us_tready),
    .us_tlast    (us_tlast),
    .seqno       (seqno)
  );

  logic [31:0] stat_tab [4];
  assign status_data = stat_tab[status_sel];

  int n_err = 0;
  int n_checks = 0;

  logic [47:0] samples [4096];
  logic [7:0]  got [$];
  logic [7:0]  exp_q [$];
  int          drv_idx = 0;
  bit          adv = 1'b0;
  bit          stall_en = 1'b0;
  int          resp_at = -1;
  bit          resp_done = 1'b0;
  int          drop_at = -1;
  bit          hold_armed = 1'b0;
  logic [7:0]  hold_byte;
  int          n_last, last_idx, n_pulse;
  bit          hs_last;
  int          cyc = 0;
  int          first_cyc;

  // Reference model state
  int          m_idx = 0;
  logic [1:0]  m_sel = 2'd0;
  bit          m_pend = 1'b0;
  logic [5:0]  m_addr;
  logic [31:0] m_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push32(input logic [31:0] w);
    exp_q.push_back(w[31:24]);
    exp_q.push_back(w[23:16]);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
  endtask

  // Expected packet from the framing rules; advances the model state.
  task automatic build_pkt(input logic [31:0] seq, input int n);
    int slots;
    logic [7:0] c0;
    logic [31:0] cw;
    logic [47:0] s;
    exp_q.delete();
    exp_q.push_back(8'hEF); exp_q.push_back(8'hFE);
    exp_q.push_back(8'h01); exp_q.push_back(8'h06);
    push32(seq);
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 3; k++) exp_q.push_back(8'h7F);
      if (m_pend) begin
        c0 = {1'b1, m_addr, ptt_in};
        cw = m_data;
        m_pend = 1'b0;
      end else begin
        c0 = {3'b000, m_sel, 2'b00, ptt_in};
        cw = stat_tab[m_sel];
        m_sel = m_sel + 2'd1;
      end
      exp_q.push_back(c0);
      push32(cw);
      slots = 504 / (6 * n + 2);
      for (int sl = 0; sl < slots; sl++) begin
        for (int r = 0; r < n; r++) begin
          s = samples[m_idx % 4096];
          m_idx++;
          exp_q.push_back(s[47:40]); exp_q.push_back(s[39:32]); exp_q.push_back(s[31:24]);
          exp_q.push_back(s[23:16]); exp_q.push_back(s[15:8]);  exp_q.push_back(s[7:0]);
        end
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
      end
      while (exp_q.size() < 8 + 512 * (f + 1)) exp_q.push_back(8'h00);
    end
  endtask

  // One clock: drive inputs at the falling edge, observe #1 later.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (adv) begin
      drv_idx++;
      adv = 1'b0;
    end
    resp_valid = 1'b0;
    if (resp_at >= 0 && !resp_done && got.size() == resp_at) begin
      resp_valid = 1'b1;
      resp_done  = 1'b1;
    end
    if (drop_at >= 0 && got.size() >= drop_at) run = 1'b0;
    us_tready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    iq_tvalid = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    iq_tdata  = samples[drv_idx % 4096];
    #1;
    hs_last = 1'b0;
    if (us_tvalid) begin
      if (hold_armed) check("hold_while_stalled", us_tdata, hold_byte);
      hold_armed = !us_tready;
      hold_byte  = us_tdata;
    end
    if (us_tvalid && us_tready) begin
      got.push_back(us_tdata);
      if (got.size() == 1) first_cyc = cyc;
      if (us_tlast) begin
        n_last++;
        last_idx = got.size() - 1;
        hs_last  = 1'b1;
      end
    end
    if (iq_tready) begin
      n_pulse++;
      adv = 1'b1;
    end
  endtask

  task automatic collect(input int stop_at);
    int budget;
    bit done;
    budget = 20000;
    done = 1'b0;
    got.delete();
    n_last = 0;
    n_pulse = 0;
    last_idx = -1;
    while (!done && budget > 0) begin
      step();
      budget--;
      if (hs_last || got.size() == stop_at) done = 1'b1;
    end
    check("collect_within_budget", done, 1);
  endtask

  task automatic cmp_pkt(input string tag);
    int bad;
    int first;
    bad = 0;
    first = -1;
    check({tag, "_length"}, got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      if (got[i] !== exp_q[i]) begin
        if (first < 0) first = i;
        bad++;
      end
    end
    check({tag, "_bytes_differing"}, bad, 0);
    if (first >= 0) $display("  %s first differing byte %0d", tag, first);
    check({tag, "_tlast_count"}, n_last, 1);
    check({tag, "_tlast_index"}, last_idx, 1031);
  endtask

  task automatic idle_gap(input logic [31:0] exp_seq);
    @(negedge clk);
    #1;
    check("idle_gap_tvalid", us_tvalid, 0);
    check("seqno", seqno, exp_seq);
  endtask

  initial begin
    logic [63:0] t;
    logic [7:0] hdr0 [8];
    int start_cyc;
    int n;
    hdr0 = '{8'hEF, 8'hFE, 8'h01, 8'h06, 8'h00, 8'h00, 8'h00, 8'h00};
    stat_tab = '{32'hA1B2C3D4, 32'h0BADF00D, 32'h5566_7788, 32'hCAFE0123};
    for (int i = 0; i < 4096; i++) begin
      t = {$urandom(), $urandom()};
      samples[i] = t[47:0];
    end

    rst = 1'b1; run = 1'b0; nrx = 3'd0; pkt_ready = 1'b0; iq_tdata = '0; iq_tvalid = 1'b0;
    ptt_in = 1'b0; resp_valid = 1'b0; resp_addr = 6'h0A; resp_data = 32'h12345678;
    us_tready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_tvalid", us_tvalid, 0);
    check("rst_tlast", us_tlast, 0);
    check("rst_tdata", us_tdata, 0);
    check("rst_iq_tready", iq_tready, 0);
    check("rst_status_sel", status_sel, 0);
    check("rst_seqno", seqno, 0);
    @(negedge clk);
    rst = 1'b0;
    run = 1'b1;

    // Single receiver, no stalls
    repeat (3) step();
    check("idle_without_pkt_ready", us_tvalid, 0);
    start_cyc = cyc;
    pkt_ready = 1'b1;
    build_pkt(32'd0, 1);
    collect(-1);
    check("first_byte_latency", first_cyc, start_cyc + 1);
    cmp_pkt("A0");
    for (int i = 0; i < 8; i++) check("A0_header", got[i], hdr0[i]);
    for (int i = 0; i < 3; i++) begin
      check("A0_sync0", got[8 + i], 8'h7F);
      check("A0_sync1", got[520 + i], 8'h7F);
    end
    check("A0_iq_pulses", n_pulse, 126);
    idle_gap(32'd1);
    build_pkt(32'd1, 1);
    collect(-1);
    cmp_pkt("A1");
    check("A1_seq_byte", got[7], 8'h01);

    // Five receivers
    nrx = 3'd4;
    idle_gap(32'd2);
    build_pkt(32'd2, 5);
    collect(-1);
    cmp_pkt("B");
    check("B_iq_pulses", n_pulse, 150);
    check("B_frame0_pad_last", got[519], 8'h00);

    // Command response during the header
    nrx = 3'd0;
    ptt_in = 1'b1;
    idle_gap(32'd3);
    m_pend = 1'b1; m_addr = 6'h0A; m_data = 32'h12345678;
    resp_at = 2; resp_done = 1'b0;
    build_pkt(32'd3, 1);
    collect(-1);
    resp_at = -1;
    cmp_pkt("C");
    check("C_c0_resp", got[11], 8'h95);
    check("C_c1..c4", {got[12], got[13], got[14], got[15]}, 32'h12345678);
    check("C_next_c0_ack", got[523][7], 1'b0);

    // Random stalls on both sides
    stall_en = 1'b1;
    for (int p = 0; p < 2; p++) begin
      nrx = 3'($urandom_range(0, 7));
      ptt_in = 1'($urandom_range(0, 1));
      idle_gap(32'd4 + 32'(p));
      n = int'(nrx) + 1;
      build_pkt(32'd4 + 32'(p), n);
      collect(-1);
      cmp_pkt("D_stalled");
      check("D_iq_pulses", n_pulse, 2 * n * (504 / (6 * n + 2)));
    end
    stall_en = 1'b0;

    // run dropped mid-packet, then raised again
    idle_gap(32'd6);
    n = int'(nrx) + 1;
    drop_at = 300;
    build_pkt(32'd6, n);
    collect(-1);
    drop_at = -1;
    cmp_pkt("E_run_drop");
    got.delete();
    repeat (50) step();
    check("E_no_new_packet", got.size(), 0);
    check("E_seqno_held", seqno, 32'd7);
    run = 1'b1;
    build_pkt(32'd0, n);
    collect(-1);
    cmp_pkt("E_restart");
    idle_gap(32'd1);

    // Reset in the middle of a packet
    collect(600);
    rst = 1'b1;
    adv = 1'b0;
    hold_armed = 1'b0;
    #1;
    check("F_rst_tvalid", us_tvalid, 0);
    check("F_rst_tdata", us_tdata, 0);
    check("F_rst_tlast", us_tlast, 0);
    check("F_rst_iq_tready", iq_tready, 0);
    check("F_rst_seqno", seqno, 0);
    check("F_rst_status_sel", status_sel, 0);
    @(negedge clk);
    rst = 1'b0;
    m_sel = 2'd0;
    m_pend = 1'b0;
    m_idx = drv_idx;
    build_pkt(32'd0, n);
    collect(-1);
    cmp_pkt("F_after_reset");
    idle_gap(32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
